// File: rtl/hs_pkg.sv
// Shared slice-mode encodings and sizing helpers
// for the hs_slice_pipe stream register slices.
package hs_pkg;

  localparam int HS_BYPASS = 0;
  localparam int HS_FWD    = 1;
  localparam int HS_SKID   = 2;
  localparam int HS_FULL   = 3;

  // Entries held by one slice: 0, 1 or 2.
  typedef logic [1:0] cnt_t;

  // Enough bits to count 2 entries per stage.
  function automatic int hs_lvl_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/hs_slice_stage.sv
// One valid/ready register slice; MODE picks
// forward, skid or fully-registered behaviour.
module hs_slice_stage
  import hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = HS_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output cnt_t             count
);

  generate
    if (MODE == HS_FWD) begin : g_fwd
      logic             v_q;
      logic [WIDTH-1:0] d_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (valid_i && ready_o) begin
          v_q <= 1'b1;
          d_q <= data_i;
        end else if (ready_i) begin
          v_q <= 1'b0;
        end
      end

      assign ready_o = !rst && (ready_i || !v_q);
      assign valid_o = !rst && v_q;
      assign data_o  = d_q;
      assign count   = {1'b0, v_q};

    end else if (MODE == HS_SKID) begin : g_skid
      logic             s_v;
      logic [WIDTH-1:0] s_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_v <= 1'b0;
          s_d <= '0;
        end else if (s_v) begin
          if (ready_i) s_v <= 1'b0;
        end else if (valid_i && ready_o && !ready_i) begin
          s_v <= 1'b1;
          s_d <= data_i;
        end
      end

      assign ready_o = !rst && !s_v;
      assign valid_o = !rst && (s_v || valid_i);
      assign data_o  = s_v ? s_d : data_i;
      assign count   = {1'b0, s_v};

    end else if (MODE == HS_FULL) begin : g_full
      logic             m_v;
      logic [WIDTH-1:0] m_d;
      logic             s_v;
      logic [WIDTH-1:0] s_d;
      logic             in_x;
      logic             out_x;

      assign in_x  = valid_i && ready_o;
      assign out_x = m_v && ready_i;

      // Skid only fills behind a full main entry,
      // so s_v alone means "both entries full".
      always_ff @(posedge clk) begin
        if (rst) begin
          m_v <= 1'b0;
          m_d <= '0;
          s_v <= 1'b0;
          s_d <= '0;
        end else if (s_v) begin
          if (out_x) begin
            m_d <= s_d;
            s_v <= 1'b0;
          end
        end else if (in_x && out_x) begin
          m_d <= data_i;
        end else if (in_x && m_v) begin
          s_v <= 1'b1;
          s_d <= data_i;
        end else if (in_x) begin
          m_v <= 1'b1;
          m_d <= data_i;
        end else if (out_x) begin
          m_v <= 1'b0;
        end
      end

      assign ready_o = !rst && !s_v;
      assign valid_o = !rst && m_v;
      assign data_o  = m_d;
      assign count   = cnt_t'(m_v) + cnt_t'(s_v);

    end else begin : g_byp
      assign ready_o = !rst && ready_i;
      assign valid_o = !rst && valid_i;
      assign data_o  = data_i;
      assign count   = '0;
    end
  endgenerate

endmodule

// File: rtl/hs_slice_pipe.sv
// Chain of STAGES valid/ready slices with an
// occupancy count for flow monitoring.
module hs_slice_pipe
  import hs_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int MODE   = HS_FULL,
  localparam int LW     = hs_lvl_w(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    level_o
);

  generate
    if (MODE == HS_BYPASS) begin : g_byp
      assign valid_o = valid_i && !rst;
      assign ready_o = ready_i && !rst;
      assign data_o  = data_i;
      assign level_o = '0;

    end else begin : g_chain
      logic             v [STAGES+1];
      logic             r [STAGES+1];
      logic [WIDTH-1:0] d [STAGES+1];
      cnt_t             cnt [STAGES];
      logic [LW-1:0]    sum;

      assign v[0]       = valid_i;
      assign d[0]       = data_i;
      assign ready_o    = r[0];
      assign valid_o    = v[STAGES];
      assign data_o     = d[STAGES];
      assign r[STAGES]  = ready_i;

      for (genvar k = 0; k < STAGES; k++) begin : g_stage
        hs_slice_stage #(
          .WIDTH (WIDTH),
          .MODE  (MODE)
        ) u_stage (
          .clk     (clk),
          .rst     (rst),
          .valid_i (v[k]),
          .ready_o (r[k]),
          .data_i  (d[k]),
          .valid_o (v[k+1]),
          .ready_i (r[k+1]),
          .data_o  (d[k+1]),
          .count   (cnt[k])
        );
      end

      always_comb begin
        sum = '0;
        for (int k = 0; k < STAGES; k++) begin
          sum = sum + LW'(cnt[k]);
        end
      end

      assign level_o = rst ? '0 : sum;
    end
  endgenerate

endmodule

// File: tb/tb_hs_slice_pipe.sv
// Scoreboard bench for hs_slice_pipe across all
// slice modes, with directed and random traffic.
module tb_hs_slice_pipe;

  localparam int W = 16;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  logic rst_m;
  logic rst4;

  logic           vi [N];
  logic           ri [N];
  logic           vo [N];
  logic           ro [N];
  logic [W-1:0]   di [N];
  logic [W-1:0]   dq [N];
  logic [3:0]     lv [N];
  logic [2:0]     lv0, lv3, lv4;
  logic [1:0]     lv1, lv2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rst4  = rst | rst_m;
  assign lv[0] = {1'b0, lv0};
  assign lv[1] = {2'b0, lv1};
  assign lv[2] = {2'b0, lv2};
  assign lv[3] = {1'b0, lv3};
  assign lv[4] = {1'b0, lv4};

  hs_slice_pipe #(.WIDTH(W), .STAGES(2), .MODE(3)) u_full (
    .clk(clk), .rst(rst),
    .valid_i(vi[0]), .ready_o(ro[0]),
    .valid_o(vo[0]), .ready_i(ri[0]),
    .data_i(di[0]), .data_o(dq[0]), .level_o(lv0));

  hs_slice_pipe #(.WIDTH(W), .STAGES(1), .MODE(2)) u_skid (
    .clk(clk), .rst(rst),
    .valid_i(vi[1]), .ready_o(ro[1]),
    .valid_o(vo[1]), .ready_i(ri[1]),
    .data_i(di[1]), .data_o(dq[1]), .level_o(lv1));

  hs_slice_pipe #(.WIDTH(W), .STAGES(1), .MODE(1)) u_fwd (
    .clk(clk), .rst(rst),
    .valid_i(vi[2]), .ready_o(ro[2]),
    .valid_o(vo[2]), .ready_i(ri[2]),
    .data_i(di[2]), .data_o(dq[2]), .level_o(lv2));

  hs_slice_pipe #(.WIDTH(W), .STAGES(2), .MODE(0)) u_byp (
    .clk(clk), .rst(rst),
    .valid_i(vi[3]), .ready_o(ro[3]),
    .valid_o(vo[3]), .ready_i(ri[3]),
    .data_i(di[3]), .data_o(dq[3]), .level_o(lv3));

  hs_slice_pipe #(.WIDTH(W), .STAGES(3), .MODE(3)) u_rst (
    .clk(clk), .rst(rst4),
    .valid_i(vi[4]), .ready_o(ro[4]),
    .valid_o(vo[4]), .ready_i(ri[4]),
    .data_i(di[4]), .data_o(dq[4]), .level_o(lv4));

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: every instance is an order-preserving queue;
  // occupancy is beats accepted minus beats delivered.
  typedef struct {
    int inst;
    int d;
  } ent_t;

  ent_t           sbq [$];
  int             lvm [N];
  logic           hold [N];
  logic [W-1:0]   held [N];

  function automatic logic rs(input int i);
    return (i == 4) ? rst4 : rst;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rs(i)) begin
        chk($sformatf("rst_level%0d", i), lv[i], 0);
        if (i != 3) begin
          chk($sformatf("rst_valid%0d", i), vo[i], 0);
          chk($sformatf("rst_ready%0d", i), ro[i], 0);
        end
        lvm[i]  = 0;
        hold[i] = 1'b0;
        for (int k = sbq.size() - 1; k >= 0; k--)
          if (sbq[k].inst == i) sbq.delete(k);
      end else begin
        chk($sformatf("level%0d", i), lv[i], lvm[i]);
        if (hold[i] && i != 3) begin
          chk($sformatf("hold_valid%0d", i), vo[i], 1);
          chk($sformatf("hold_data%0d", i), dq[i], held[i]);
        end
        if (i == 3) begin
          chk("byp_valid", vo[i], vi[i]);
          chk("byp_ready", ro[i], ri[i]);
          chk("byp_data", dq[i], di[i]);
        end
        if (vi[i] && ro[i]) begin
          ent_t e;
          e.inst = i;
          e.d    = int'(di[i]);
          sbq.push_back(e);
          lvm[i]++;
        end
        if (vo[i] && ri[i]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].inst == i) idx = k;
          if (idx < 0) begin
            chk($sformatf("spurious_out%0d", i), 1, 0);
          end else begin
            chk($sformatf("order%0d", i), dq[i], sbq[idx].d);
            sbq.delete(idx);
          end
          lvm[i]--;
        end
        hold[i] = vo[i] && !ri[i];
        held[i] = dq[i];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int blk;
    logic a;
    int left;

    rst   = 1'b1;
    rst_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      vi[i] = 1'b0;
      ri[i] = 1'b0;
      di[i] = '0;
    end

    // Reset held across two rising edges.
    tick();
    smp();
    chk("reset_ready", ro[0], 0);
    chk("reset_valid", vo[0], 0);
    chk("reset_level", lv0, 0);
    tick();
    rst = 1'b0;

    // Streaming latency through MODE 3, two stages.
    vi[0] = 1'b1;
    ri[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      di[0] = W'(k);
      smp();
      if (k == 1) begin
        chk("first_ready", ro[0], 1);
        chk("first_ready_skid", ro[1], 1);
        chk("first_ready_fwd", ro[2], 1);
      end
      chk("lat_valid", vo[0], (k >= 3) ? 1 : 0);
      if (k >= 3) chk("lat_data", dq[0], k - 2);
      chk("lat_level", lv0, (k - 1 > 2) ? 2 : k - 1);
      tick();
    end
    vi[0] = 1'b0;
    repeat (4) tick();

    // Backpressure fill.
    ri[0] = 1'b0;
    vi[0] = 1'b1;
    di[0] = W'(10);
    acc   = 0;
    blk   = -1;
    for (int c = 0; c < 12 && blk < 0; c++) begin
      smp();
      a = ro[0];
      if (!a) blk = acc;
      tick();
      if (a) begin
        acc++;
        di[0] = di[0] + 1'b1;
      end
    end
    chk("fill_accepts", blk, 4);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("fill_level", lv0, 4);
      chk("fill_valid", vo[0], 1);
      chk("fill_data", dq[0], 10);
      chk("fill_ready", ro[0], 0);
      tick();
    end
    ri[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (c == 0) chk("release_data0", dq[0], 10);
      if (c == 1) chk("release_data1", dq[0], 11);
      a = vi[0] && ro[0];
      tick();
      if (a) begin
        if (di[0] == W'(15)) vi[0] = 1'b0;
        else di[0] = di[0] + 1'b1;
      end
    end
    chk("release_sent_all", vi[0], 0);

    // Skid capture on MODE 2.
    vi[1] = 1'b1;
    di[1] = W'(6);
    ri[1] = 1'b0;
    smp();
    chk("skid_ready0", ro[1], 1);
    chk("skid_valid0", vo[1], 1);
    chk("skid_data0", dq[1], 6);
    tick();
    di[1] = W'(16);
    smp();
    chk("skid_ready1", ro[1], 0);
    chk("skid_data1", dq[1], 6);
    chk("skid_level1", lv1, 1);
    tick();
    ri[1] = 1'b1;
    smp();
    chk("skid_ready2", ro[1], 0);
    chk("skid_data2", dq[1], 6);
    tick();
    smp();
    chk("skid_ready3", ro[1], 1);
    chk("skid_valid3", vo[1], 1);
    chk("skid_data3", dq[1], 16);
    chk("skid_level3", lv1, 0);
    tick();
    vi[1] = 1'b0;
    smp();
    chk("skid_idle", vo[1], 0);
    tick();

    // Single-cycle bubble through MODE 1.
    ri[2] = 1'b1;
    tick();
    vi[2] = 1'b1;
    di[2] = W'(16'h00a5);
    smp();
    chk("fwd_ready0", ro[2], 1);
    chk("fwd_valid0", vo[2], 0);
    tick();
    vi[2] = 1'b0;
    smp();
    chk("fwd_ready1", ro[2], 1);
    chk("fwd_valid1", vo[2], 1);
    chk("fwd_data1", dq[2], 16'h00a5);
    tick();
    smp();
    chk("fwd_ready2", ro[2], 1);
    chk("fwd_valid2", vo[2], 0);
    tick();

    // Pass-through; the monitor compares each cycle.
    for (int c = 0; c < 100; c++) begin
      vi[3] = 1'($urandom_range(0, 1));
      ri[3] = 1'($urandom_range(0, 1));
      di[3] = W'($urandom);
      tick();
    end
    vi[3] = 1'b0;
    ri[3] = 1'b0;

    // Mid-stream reset with five beats held.
    ri[4] = 1'b0;
    vi[4] = 1'b1;
    di[4] = W'(100);
    acc   = 0;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      smp();
      a = ro[4];
      tick();
      if (a) begin
        acc++;
        di[4] = di[4] + 1'b1;
        if (acc == 5) vi[4] = 1'b0;
      end
    end
    tick();
    tick();
    smp();
    chk("mrst_pre_level", lv4, 5);
    chk("mrst_pre_valid", vo[4], 1);
    tick();
    rst_m = 1'b1;
    smp();
    chk("mrst_ready", ro[4], 0);
    chk("mrst_valid", vo[4], 0);
    chk("mrst_level", lv4, 0);
    tick();
    rst_m = 1'b0;
    smp();
    chk("mrst_after_valid", vo[4], 0);
    chk("mrst_after_level", lv4, 0);
    chk("mrst_after_ready", ro[4], 1);
    ri[4] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      smp();
      chk("mrst_no_stale", vo[4], 0);
    end
    tick();

    // Random traffic on the registered modes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        vi[i] = ($urandom_range(0, 3) != 0);
        ri[i] = ($urandom_range(0, 2) != 0);
        di[i] = W'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vi[i] = 1'b0;
      ri[i] = 1'b1;
    end
    repeat (10) tick();
    smp();
    left = sbq.size();
    chk("drain_empty", left, 0);
    chk("drain_level0", lv0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
